// File: rtl/car_sensor_ctrl.sv
// rtl/car_sensor_ctrl.sv - country-road loop debounce, vehicle request FSM and stuck-sensor detect
// Vehicle arrival counter is built only when CAR_SENSOR_COUNT_EN is defined.
module car_sensor_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned STUCK_CYC    = 200,
    parameter logic [2:0]  GREEN_CODE   = 3'd2
) (
    input  logic       CLOCK,
    input  logic       CLEAR,
    input  logic       LOOP_RAW,
    input  logic [2:0] CNTRY_SIG,
    input  logic       VEH_COUNT_CLR,
    output logic       CAR_ON_CNTRY_RD,
    output logic       SENSOR_FAULT,
    output logic [7:0] VEH_COUNT
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SERVE,
        S_FAULT
    } state_t;

    localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE_CYC - 1);
    localparam logic [15:0] STUCK_MAX  = 16'(STUCK_CYC);
    localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYC - 1);

    // CLEAR asserts asynchronously but releases on a clock edge so all flops leave reset together.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic        loop_meta_q;
    logic        loop_sync_q;
    logic [3:0]  deb_cnt_q;
    logic [3:0]  deb_cnt_d;
    logic        filt_q;
    logic        filt_d;
    logic        filt_prev_q;
    logic [15:0] stuck_cnt_q;
    logic [15:0] stuck_cnt_d;
    state_t      state_q;
    state_t      state_d;
    logic        car_q;
    logic        fault_q;
    logic        arrival;
    logic        stuck;
    logic        green;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            loop_meta_q <= 1'b0;
            loop_sync_q <= 1'b0;
        end else begin
            loop_meta_q <= LOOP_RAW;
            loop_sync_q <= loop_meta_q;
        end
    end

    // Filtered level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
        deb_cnt_d = 4'd0;
        filt_d    = filt_q;
        if (loop_sync_q != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = loop_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        stuck_cnt_d = 16'd0;
        if (filt_q) begin
            stuck_cnt_d = (stuck_cnt_q == STUCK_MAX) ? STUCK_MAX : stuck_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q   <= 4'd0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            stuck_cnt_q <= 16'd0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

    assign arrival = filt_q & ~filt_prev_q;
    assign green   = (CNTRY_SIG == GREEN_CODE);
    // Current cycle is the STUCK_CYC-th consecutive filtered-high cycle.
    assign stuck   = filt_q && (stuck_cnt_q >= STUCK_LAST);

    always_comb begin
        state_d = state_q;
        if (stuck && (state_q != S_FAULT)) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arrival) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (green) state_d = S_SERVE;
                end
                S_SERVE: begin
                    if (!filt_q) begin
                        state_d = S_IDLE;
                    end else if (!green) begin
                        state_d = S_WAIT;
                    end
                end
                S_FAULT: begin
                    if (!filt_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            car_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            car_q   <= (state_d != S_IDLE);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign CAR_ON_CNTRY_RD = car_q;
    assign SENSOR_FAULT    = fault_q;

`ifdef CAR_SENSOR_COUNT_EN
    logic [7:0] veh_cnt_q;
    logic [7:0] veh_cnt_d;

    always_comb begin
        veh_cnt_d = veh_cnt_q;
        if (VEH_COUNT_CLR) begin
            veh_cnt_d = 8'd0;
        end else if (arrival && (veh_cnt_q != 8'hFF)) begin
            veh_cnt_d = veh_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            veh_cnt_q <= 8'd0;
        end else begin
            veh_cnt_q <= veh_cnt_d;
        end
    end

    assign VEH_COUNT = veh_cnt_q;
`else
    logic unused_veh_count_clr;
    assign unused_veh_count_clr = VEH_COUNT_CLR;
    assign VEH_COUNT            = 8'd0;
`endif

endmodule

// File: tb/tb_car_sensor_ctrl.sv
// tb/tb_car_sensor_ctrl.sv - scoreboard bench for car_sensor_ctrl against a history-based reference model
module tb_car_sensor_ctrl;
    localparam int         DEB   = 4;
    localparam int         STUCK = 200;
    localparam logic [2:0] GREEN = 3'd2;
`ifdef CAR_SENSOR_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SERVE = 2;
    localparam int M_FAULT = 3;

    logic       clk      = 1'b0;
    logic       clear_n  = 1'b0;
    logic       loop_raw = 1'b0;
    logic [2:0] sig      = 3'd0;
    logic       cnt_clr  = 1'b0;
    logic       car;
    logic       fault;
    logic [7:0] vcnt;

    int    errors = 0;
    int    checks = 0;
    string phase  = "reset";

    typedef struct {
        int car;
        int fault;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    bit raw_h[$];
    bit filt_h[$];
    int mst  = M_IDLE;
    int mcnt = 0;
    int hold = 2;

    car_sensor_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .STUCK_CYC   (STUCK),
        .GREEN_CODE  (GREEN)
    ) dut (
        .CLOCK          (clk),
        .CLEAR          (clear_n),
        .LOOP_RAW       (loop_raw),
        .CNTRY_SIG      (sig),
        .VEH_COUNT_CLR  (cnt_clr),
        .CAR_ON_CNTRY_RD(car),
        .SENSOR_FAULT   (fault),
        .VEH_COUNT      (vcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, phase, act, expv);
        end
    endtask

    // Predicts outputs after the coming edge from the full sample history since reset release.
    function automatic void model_step(input bit raw, input logic [2:0] s, input bit clr, input bit clear_hi);
        int   n;
        int   k;
        int   run;
        bit   fp;
        bit   fp2;
        bit   flip;
        bit   sv;
        bit   arrival;
        exp_t e;
        if (!clear_hi) begin
            raw_h.delete();
            filt_h.delete();
            mst  = M_IDLE;
            mcnt = 0;
            hold = 2;
        end else if (hold > 0) begin
            hold--;
        end else begin
            n    = raw_h.size() + 1;
            fp   = (filt_h.size() >= 1) ? filt_h[filt_h.size()-1] : 1'b0;
            fp2  = (filt_h.size() >= 2) ? filt_h[filt_h.size()-2] : 1'b0;
            flip = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                k  = n - j;
                sv = (k >= 2) ? raw_h[k-2] : 1'b0;
                if (sv == fp) flip = 1'b0;
            end
            run = 0;
            for (int i = filt_h.size() - 1; i >= 0; i--) begin
                if (!filt_h[i]) break;
                run++;
            end
            arrival = fp && !fp2;
            if (mst != M_FAULT && run >= STUCK) begin
                mst = M_FAULT;
            end else if (mst == M_IDLE) begin
                if (arrival) mst = M_WAIT;
            end else if (mst == M_WAIT) begin
                if (s == GREEN) mst = M_SERVE;
            end else if (mst == M_SERVE) begin
                if (!fp) mst = M_IDLE;
                else if (s != GREEN) mst = M_WAIT;
            end else begin
                if (!fp) mst = M_IDLE;
            end
            if (CNT_EN != 0) begin
                if (clr) mcnt = 0;
                else if (arrival && mcnt < 255) mcnt++;
            end
            raw_h.push_back(raw);
            filt_h.push_back(fp ^ flip);
        end
        e.car   = (mst != M_IDLE) ? 1 : 0;
        e.fault = (mst == M_FAULT) ? 1 : 0;
        e.cnt   = mcnt;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input bit raw, input logic [2:0] s, input bit clr);
        loop_raw = raw;
        sig      = s;
        cnt_clr  = clr;
        model_step(raw, s, clr, clear_n);
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input bit raw, input logic [2:0] s);
        for (int i = 0; i < n; i++) tick(raw, s, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_car", int'(car), e.car);
                chk("sb_fault", int'(fault), e.fault);
                chk("sb_count", int'(vcnt), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int len;
        bit r;
        logic [2:0] s;
        @(negedge clk);
        run_n(3, 1'b0, 3'd0);
        chk("reset_car", int'(car), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_count", int'(vcnt), 0);
        clear_n = 1'b1;
        run_n(4, 1'b0, 3'd0);

        phase = "clean_arrival";
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 3'd0, 1'b0);
            if (i == DEB + 2) chk("arrival_before_edge", int'(car), 0);
            if (i == DEB + 3) begin
                chk("arrival_at_edge", int'(car), 1);
                chk("arrival_count", int'(vcnt), CNT_EN);
            end
        end

        phase = "wait_drop_then_green";
        run_n(10, 1'b0, 3'd0);
        chk("wait_latched", int'(car), 1);
        tick(1'b0, GREEN, 1'b0);
        chk("serve_entered", int'(car), 1);
        tick(1'b0, GREEN, 1'b0);
        chk("serve_released", int'(car), 0);
        run_n(4, 1'b0, 3'd0);

        phase = "serve_to_wait";
        run_n(8, 1'b1, 3'd0);
        tick(1'b1, GREEN, 1'b0);
        tick(1'b1, 3'd0, 1'b0);
        chk("back_to_wait", int'(car), 1);
        tick(1'b1, GREEN, 1'b0);
        for (int i = 1; i <= DEB + 3; i++) begin
            tick(1'b0, GREEN, 1'b0);
            if (i == DEB + 2) chk("release_hold", int'(car), 1);
            if (i == DEB + 3) chk("release_edge", int'(car), 0);
        end
        chk("two_arrivals", int'(vcnt), 2 * CNT_EN);

        phase = "glitch";
        run_n(3, 1'b1, 3'd0);
        run_n(10, 1'b0, 3'd0);
        chk("glitch_car", int'(car), 0);
        chk("glitch_count", int'(vcnt), 2 * CNT_EN);

        phase = "stuck";
        for (int i = 1; i <= 300; i++) begin
            tick(1'b1, 3'd0, 1'b0);
            if (i == DEB + 2 + STUCK - 1) chk("stuck_before", int'(fault), 0);
            if (i == DEB + 2 + STUCK) chk("stuck_at", int'(fault), 1);
        end
        chk("stuck_fault", int'(fault), 1);
        chk("stuck_failsafe", int'(car), 1);
        for (int i = 1; i <= DEB + 3; i++) begin
            tick(1'b0, 3'd0, 1'b0);
            if (i == DEB + 2) chk("fault_hold", int'(fault), 1);
            if (i == DEB + 3) begin
                chk("fault_clear", int'(fault), 0);
                chk("fault_idle", int'(car), 0);
            end
        end

        phase = "random";
        for (int b = 0; b < 200; b++) begin
            len = $urandom_range(1, 10);
            r   = 1'($urandom_range(0, 1));
            s   = 3'($urandom_range(0, 7));
            for (int i = 0; i < len; i++) tick(r, s, ($urandom_range(0, 39) == 0));
        end
        run_n(8, 1'b0, 3'd0);

        phase = "saturate";
        for (int a = 0; a < 260; a++) begin
            s = 3'($urandom_range(0, 7));
            run_n(8, 1'b1, s);
            run_n(8, 1'b0, s);
        end
        chk("saturated", int'(vcnt), 255 * CNT_EN);
        phase = "clear_with_arrival";
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 3'd0, (i == DEB + 3));
            if (i == DEB + 2) chk("pre_clear", int'(vcnt), 255 * CNT_EN);
            if (i == DEB + 3) chk("clear_wins", int'(vcnt), 0);
        end
        run_n(8, 1'b0, 3'd0);

        phase = "reset_mid_op";
        tick(1'b0, 3'd0, 1'b1);
        for (int a = 0; a < 4; a++) begin
            run_n(8, 1'b1, 3'd0);
            run_n(8, 1'b0, 3'd0);
        end
        run_n(8, 1'b1, 3'd0);
        run_n(2, 1'b1, GREEN);
        chk("serve_car", int'(car), 1);
        chk("serve_count", int'(vcnt), 5 * CNT_EN);
        clear_n = 1'b0;
        #1;
        chk("clear_car", int'(car), 0);
        chk("clear_fault", int'(fault), 0);
        chk("clear_count", int'(vcnt), 0);
        run_n(3, 1'b1, GREEN);
        clear_n = 1'b1;
        run_n(2, 1'b1, 3'd0);
        for (int i = 1; i <= DEB + 3; i++) begin
            tick(1'b1, 3'd0, 1'b0);
            if (i == DEB + 2) chk("rearm_before", int'(car), 0);
            if (i == DEB + 3) begin
                chk("rearm_car", int'(car), 1);
                chk("rearm_count", int'(vcnt), CNT_EN);
            end
        end
        run_n(6, 1'b0, 3'd0);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
